// File: rtl/arb_pkg.sv
// arb_pkg: shared types and defaults for the unified-memory port arbiter.
package arb_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;

   // Instruction returned on the fetch port while nothing has been fetched yet.
   localparam logic [15:0] NOP_INST = 16'h1000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/fetch_line_buf.sv
// fetch_line_buf: one-entry fetch buffer (tag, valid bit, instruction).
// Present only when MEM_ARB_FETCH_BUF_EN is defined.
// Fill has priority over a same-cycle invalidate.
// The two never coincide because fills happen in BUSY_I and invalidates in IDLE.
`ifdef MEM_ARB_FETCH_BUF_EN
module fetch_line_buf
   import arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit,
   output logic [15:0]       data,
   input  logic              fill_en,
   input  logic [ADDR_W-1:0] fill_addr,
   input  logic [15:0]       fill_data,
   input  logic              inv_en,
   input  logic [ADDR_W-1:0] inv_addr
);

   logic [ADDR_W-1:0] tag_r;
   logic              tag_v_r;
   logic [15:0]       data_r;

   // Tag/data storage: reset clears, completed fetch fills, matching store invalidates.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_r   <= '0;
         tag_v_r <= 1'b0;
         data_r  <= NOP_INST;
      end else if (fill_en) begin
         tag_r   <= fill_addr;
         tag_v_r <= 1'b1;
         data_r  <= fill_data;
      end else if (inv_en && (inv_addr == tag_r)) begin
         tag_v_r <= 1'b0;
      end else begin
         tag_v_r <= tag_v_r;
      end
   end

   assign hit  = tag_v_r && (lookup_addr == tag_r);
   assign data = data_r;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between
// instruction fetch and the data stage.
// It grants one access at a time and counts out MEM_LAT.
// It returns read data with a one-cycle valid pulse.
// Optional feature: define MEM_ARB_FETCH_BUF_EN to add a one-entry fetch buffer
// that answers repeated fetches without a memory access.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [15:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   input  logic              halt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_fetch,
   output logic              stall_mem
);

   arb_state_t        state_r;
   logic [2:0]        cnt_r;
   logic              last_was_d_r;

   logic              mem_en_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              if_valid_r;
   logic [15:0]       if_rdata_r;
   logic              dm_valid_r;
   logic [DATA_W-1:0] dm_rdata_r;

   logic              hit_s;
   logic              fetch_ok_s;
   logic              grant_i_s;
   logic              grant_d_s;
   logic [15:0]       buf_data_s;

`ifdef MEM_ARB_FETCH_BUF_EN
   logic buf_hit_s;
   logic fill_en_s;
   logic inv_en_s;

   // Every completed memory fetch refills the buffer.
   // A granted store to the tagged address kills it.
   assign fill_en_s = (state_r == BUSY_I) && (cnt_r == 3'd0);
   assign inv_en_s  = grant_d_s && dm_we;
   assign hit_s     = (state_r == IDLE) && if_req && !halt && buf_hit_s;

   fetch_line_buf #(
      .ADDR_W (ADDR_W)
   ) u_fetch_line_buf (
      .clk         (clk),
      .rst         (rst),
      .lookup_addr (if_addr),
      .hit         (buf_hit_s),
      .data        (buf_data_s),
      .fill_en     (fill_en_s),
      .fill_addr   (mem_addr_r),
      .fill_data   (mem_rdata[15:0]),
      .inv_en      (inv_en_s),
      .inv_addr    (dm_addr)
   );
`else
   assign hit_s      = 1'b0;
   assign buf_data_s = NOP_INST;
`endif

   // Arbitration in IDLE: data wins unless it won last time and fetch is eligible.
   // Halt and buffer hits remove fetch from contention.
   always_comb begin
      fetch_ok_s = 1'b0;
      grant_d_s  = 1'b0;
      grant_i_s  = 1'b0;
      if (state_r == IDLE) begin
         fetch_ok_s = if_req && !halt && !hit_s;
         grant_d_s  = dm_req && !(fetch_ok_s && last_was_d_r);
         grant_i_s  = fetch_ok_s && !grant_d_s;
      end else begin
         fetch_ok_s = 1'b0;
         grant_d_s  = 1'b0;
         grant_i_s  = 1'b0;
      end
   end

   // Sequencer: grant captures the request and strobes memory.
   // The latency counter runs down, then the read data is captured with a valid pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= IDLE;
         cnt_r        <= 3'd0;
         last_was_d_r <= 1'b0;
         mem_en_r     <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= '0;
         mem_wdata_r  <= '0;
         if_valid_r   <= 1'b0;
         if_rdata_r   <= NOP_INST;
         dm_valid_r   <= 1'b0;
         dm_rdata_r   <= '0;
      end else begin
         mem_en_r   <= 1'b0;
         mem_we_r   <= 1'b0;
         if_valid_r <= 1'b0;
         dm_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_d_s) begin
                  state_r      <= BUSY_D;
                  cnt_r        <= 3'(MEM_LAT);
                  last_was_d_r <= 1'b1;
                  mem_en_r     <= 1'b1;
                  mem_we_r     <= dm_we;
                  mem_addr_r   <= dm_addr;
                  mem_wdata_r  <= dm_wdata;
               end else if (grant_i_s) begin
                  state_r      <= BUSY_I;
                  cnt_r        <= 3'(MEM_LAT);
                  last_was_d_r <= 1'b0;
                  mem_en_r     <= 1'b1;
                  mem_addr_r   <= if_addr;
               end else begin
                  state_r <= IDLE;
               end
               if (hit_s) begin
                  if_valid_r <= 1'b1;
                  if_rdata_r <= buf_data_s;
               end else begin
                  if_rdata_r <= if_rdata_r;
               end
            end
            BUSY_I: begin
               if (cnt_r == 3'd0) begin
                  state_r    <= IDLE;
                  if_valid_r <= 1'b1;
                  if_rdata_r <= mem_rdata[15:0];
               end else begin
                  cnt_r <= cnt_r - 3'd1;
               end
            end
            BUSY_D: begin
               if (cnt_r == 3'd0) begin
                  state_r    <= IDLE;
                  dm_valid_r <= 1'b1;
                  dm_rdata_r <= mem_rdata;
               end else begin
                  cnt_r <= cnt_r - 3'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= 3'd0;
            end
         endcase
      end
   end

   assign mem_en      = mem_en_r;
   assign mem_we      = mem_we_r;
   assign mem_addr    = mem_addr_r;
   assign mem_wdata   = mem_wdata_r;
   assign if_valid    = if_valid_r;
   assign if_rdata    = if_rdata_r;
   assign dm_valid    = dm_valid_r;
   assign dm_rdata    = dm_rdata_r;

   assign stall_fetch = if_req & ~if_valid_r;
   assign stall_mem   = dm_req & ~dm_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a transaction-level reference model.
// The model uses grant time, completion time and shadow memory; it is compared every cycle.
module tb_mem_port_arbiter;

   localparam int L = 2;
   localparam int N = 4096;
`ifdef MEM_ARB_FETCH_BUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_valid;
   logic [15:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [15:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_valid;
   logic [31:0] dm_rdata;
   logic        halt;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_fetch;
   logic        stall_mem;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(L), .ADDR_W(16), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_valid(dm_valid), .dm_rdata(dm_rdata), .halt(halt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_fetch(stall_fetch), .stall_mem(stall_mem)
   );

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
   } dop_t;

   logic [15:0] fq[$];
   dop_t        dq[$];
   logic        rst_drv, halt_drv;

   int cyc, n_cmp, n_bad;
   int n_mem_en, n_if_v, n_dm_v;
   logic [15:0] grant_log[$];

   // reference model state
   int          free_at;
   bit          last_d, started;
   bit          tag_v, fill_pend;
   logic [15:0] tag_a, tag_d, fill_a, fill_d;
   int          fill_at;
   logic [31:0] ref_mem[256];
   logic [31:0] env_mem[256];

   bit          e_en[N], e_we[N], e_iv[N], e_dv[N];
   bit          s_ma[N], s_mw[N], s_ir[N], s_dr[N], k_dr[N];
   logic [15:0] v_ma[N], v_ir[N];
   logic [31:0] v_mw[N], v_dr[N];
   logic [15:0] c_ma, c_ir;
   logic [31:0] c_mw, c_dr;
   bit          c_dr_k;

   bit          resp_v[N];
   logic [31:0] resp_d[N];
   bit          lg_en[N], lg_iv[N], lg_dv[N], lg_sm[N];
   logic [31:0] lg_dr[N];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   // Model: decide what happens in cycle cyc from the spec rules and schedule outputs.
   task automatic model_step();
      bit hit, fe, gd, gi;
      int done;
      logic [7:0] ix;
      if (rst_drv == 1'b0) begin
         for (int k = cyc + 1; k < cyc + 16; k++) begin
            e_en[k] = 1'b0; e_we[k] = 1'b0; e_iv[k] = 1'b0; e_dv[k] = 1'b0;
            s_ma[k] = 1'b0; s_mw[k] = 1'b0; s_ir[k] = 1'b0; s_dr[k] = 1'b0;
         end
         s_ma[cyc+1] = 1'b1; v_ma[cyc+1] = 16'h0000;
         s_mw[cyc+1] = 1'b1; v_mw[cyc+1] = 32'h0000_0000;
         s_ir[cyc+1] = 1'b1; v_ir[cyc+1] = 16'h1000;
         s_dr[cyc+1] = 1'b1; k_dr[cyc+1] = 1'b1; v_dr[cyc+1] = 32'h0000_0000;
         free_at = cyc + 1; last_d = 1'b0; tag_v = 1'b0; fill_pend = 1'b0;
         started = 1'b1;
      end else begin
         if (fill_pend && cyc >= fill_at) begin
            tag_v = 1'b1; tag_a = fill_a; tag_d = fill_d; fill_pend = 1'b0;
         end
         if (cyc >= free_at) begin
            hit  = BUF && if_req && !halt && tag_v && (if_addr == tag_a);
            fe   = if_req && !halt && !hit;
            gd   = dm_req && !(fe && last_d);
            gi   = fe && !gd;
            done = cyc + L + 2;
            if (hit) begin
               e_iv[cyc+1] = 1'b1; s_ir[cyc+1] = 1'b1; v_ir[cyc+1] = tag_d;
            end
            if (gd) begin
               ix = dm_addr[7:0];
               e_en[cyc+1] = 1'b1; e_we[cyc+1] = dm_we;
               s_ma[cyc+1] = 1'b1; v_ma[cyc+1] = dm_addr;
               e_dv[done] = 1'b1; s_dr[done] = 1'b1;
               if (dm_we) begin
                  s_mw[cyc+1] = 1'b1; v_mw[cyc+1] = dm_wdata;
                  ref_mem[ix] = dm_wdata;
                  k_dr[done] = 1'b0;
                  if (dm_addr == tag_a) tag_v = 1'b0;
               end else begin
                  k_dr[done] = 1'b1; v_dr[done] = ref_mem[ix];
               end
               free_at = done; last_d = 1'b1;
            end else if (gi) begin
               ix = if_addr[7:0];
               e_en[cyc+1] = 1'b1; e_we[cyc+1] = 1'b0;
               s_ma[cyc+1] = 1'b1; v_ma[cyc+1] = if_addr;
               e_iv[done] = 1'b1; s_ir[done] = 1'b1; v_ir[done] = ref_mem[ix][15:0];
               fill_pend = 1'b1; fill_at = done; fill_a = if_addr; fill_d = ref_mem[ix][15:0];
               free_at = done; last_d = 1'b0;
            end
         end
      end
   endtask

   // One clock cycle: drive inputs, check stalls, advance model, then check registered outputs.
   task automatic tick();
      logic [7:0] ix;
      rst      = rst_drv;
      halt     = halt_drv;
      if_req   = (fq.size() > 0);
      if_addr  = (fq.size() > 0) ? fq[0] : 16'h0000;
      dm_req   = (dq.size() > 0);
      dm_we    = (dq.size() > 0) ? dq[0].we : 1'b0;
      dm_addr  = (dq.size() > 0) ? dq[0].addr : 16'h0000;
      dm_wdata = (dq.size() > 0) ? dq[0].wdata : 32'h0000_0000;
      mem_rdata = resp_v[cyc] ? resp_d[cyc] : (32'hBAD0_0000 | 32'(cyc));
      #1;
      if (started) begin
         chk("stall_fetch", stall_fetch, if_req & ~e_iv[cyc]);
         chk("stall_mem", stall_mem, dm_req & ~e_dv[cyc]);
      end
      lg_sm[cyc] = stall_mem;
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= N - 16) begin
         $display("FAIL cycle_budget cycle=%0d actual=over required=under", cyc);
         $fatal(1, "cycle budget exhausted");
      end
      if (s_ma[cyc]) c_ma = v_ma[cyc];
      if (s_mw[cyc]) c_mw = v_mw[cyc];
      if (s_ir[cyc]) c_ir = v_ir[cyc];
      if (s_dr[cyc]) begin c_dr = v_dr[cyc]; c_dr_k = k_dr[cyc]; end
      if (started) begin
         chk("mem_en", mem_en, e_en[cyc]);
         chk("if_valid", if_valid, e_iv[cyc]);
         chk("dm_valid", dm_valid, e_dv[cyc]);
         chk("mem_addr", mem_addr, c_ma);
         chk("if_rdata", if_rdata, c_ir);
         if (e_en[cyc]) chk("mem_we", mem_we, e_we[cyc]);
         if (e_en[cyc] && e_we[cyc]) chk("mem_wdata", mem_wdata, c_mw);
         if (c_dr_k) chk("dm_rdata", dm_rdata, c_dr);
      end
      lg_en[cyc] = mem_en; lg_iv[cyc] = if_valid; lg_dv[cyc] = dm_valid; lg_dr[cyc] = dm_rdata;
      if (mem_en === 1'b1) begin
         ix = mem_addr[7:0];
         if (mem_we === 1'b1) begin
            env_mem[ix] = mem_wdata; resp_d[cyc+L] = mem_wdata;
         end else begin
            resp_d[cyc+L] = env_mem[ix];
         end
         resp_v[cyc+L] = 1'b1;
         grant_log.push_back(mem_addr);
         n_mem_en++;
      end
      if (if_valid === 1'b1) begin
         n_if_v++;
         if (fq.size() > 0) void'(fq.pop_front());
      end
      if (dm_valid === 1'b1) begin
         n_dm_v++;
         if (dq.size() > 0) void'(dq.pop_front());
      end
   endtask

   task automatic drain(input int budget);
      int i;
      i = 0;
      while ((fq.size() > 0 || dq.size() > 0) && i < budget) begin
         tick();
         i++;
      end
      n_cmp++;
      if (fq.size() > 0 || dq.size() > 0) begin
         n_bad++;
         $display("FAIL drain_timeout cycle=%0d actual=%0d pending required=0", cyc, fq.size() + dq.size());
         fq.delete();
         dq.delete();
      end
   endtask

   task automatic do_reset(input int n);
      rst_drv = 1'b0;
      fq.delete();
      dq.delete();
      repeat (n) tick();
      rst_drv = 1'b1;
   endtask

   initial begin
      int c0, b0, b1;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 32'hC300_5A00 | (32'(i) << 16) | 32'(i);
         env_mem[i] = ref_mem[i];
      end
      ref_mem[8'h10] = 32'hDEAD_BEEF;
      env_mem[8'h10] = 32'hDEAD_BEEF;
      cyc = 0; n_cmp = 0; n_bad = 0; n_mem_en = 0; n_if_v = 0; n_dm_v = 0;
      free_at = 0; started = 1'b0; last_d = 1'b0; tag_v = 1'b0; fill_pend = 1'b0;
      c_ma = 16'h0; c_mw = 32'h0; c_ir = 16'h0; c_dr = 32'h0; c_dr_k = 1'b0;
      halt_drv = 1'b0;

      // reset values
      do_reset(3);
      chk("rst_if_rdata", if_rdata, 32'h0000_1000);
      chk("rst_dm_rdata", dm_rdata, 32'h0000_0000);
      chk("rst_mem_en", mem_en, 32'h0);
      chk("rst_mem_we", mem_we, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_if_valid", if_valid, 32'h0);
      chk("rst_dm_valid", dm_valid, 32'h0);

      // single load
      dq.push_back(dop_t'{1'b0, 16'h0010, 32'h0});
      c0 = cyc;
      drain(20);
      repeat (3) tick();
      chk("load_mem_en_c1", lg_en[c0+1], 32'h1);
      chk("load_dm_valid_c3", lg_dv[c0+3], 32'h0);
      chk("load_dm_valid_c4", lg_dv[c0+4], 32'h1);
      chk("load_dm_rdata_c4", lg_dr[c0+4], 32'hDEAD_BEEF);
      for (int k = 0; k < 4; k++) chk("load_stall_mem", lg_sm[c0+k], 32'h1);
      chk("load_stall_mem_c4", lg_sm[c0+4], 32'h0);

      // contention: D, I, D, I
      do_reset(2);
      grant_log.delete();
      for (int k = 0; k < 4; k++) begin
         fq.push_back(16'h0030 + 16'(k));
         dq.push_back(dop_t'{1'b0, 16'h0040 + 16'(k), 32'h0});
      end
      drain(200);
      repeat (2) tick();
      chk("cont_grants", grant_log.size(), 32'd8);
      chk("cont_g0", grant_log[0], 32'h40);
      chk("cont_g1", grant_log[1], 32'h30);
      chk("cont_g2", grant_log[2], 32'h41);
      chk("cont_g3", grant_log[3], 32'h31);

      // halt blocks new fetch, in-flight fetch completes
      halt_drv = 1'b1;
      b0 = n_mem_en;
      fq.push_back(16'h0050);
      repeat (8) tick();
      chk("halt_no_grant", n_mem_en - b0, 32'd0);
      halt_drv = 1'b0;
      tick();
      halt_drv = 1'b1;
      b1 = n_if_v;
      repeat (8) tick();
      chk("halt_inflight_valid", n_if_v - b1, 32'd1);
      chk("halt_fetch_done", fq.size(), 32'd0);
      halt_drv = 1'b0;

      // reset in the cycle after mem_en
      do_reset(2);
      dq.push_back(dop_t'{1'b0, 16'h0010, 32'h0});
      c0 = cyc;
      tick();
      tick();
      rst_drv = 1'b0;
      dq.delete();
      b0 = n_dm_v;
      tick();
      rst_drv = 1'b1;
      repeat (6) tick();
      chk("rstmid_mem_en_c1", lg_en[c0+1], 32'h1);
      chk("rstmid_mem_en_c3", lg_en[c0+3], 32'h0);
      chk("rstmid_no_valid", n_dm_v - b0, 32'd0);
      chk("rstmid_dm_rdata", dm_rdata, 32'h0);
      chk("rstmid_if_rdata", if_rdata, 32'h1000);

      // fetch, store to same address, refetch, then repeat another address
      do_reset(2);
      fq.push_back(16'h0020);
      drain(20);
      repeat (2) tick();
      dq.push_back(dop_t'{1'b1, 16'h0020, 32'h1234_5678});
      drain(20);
      repeat (2) tick();
      b0 = n_mem_en;
      fq.push_back(16'h0020);
      drain(20);
      repeat (2) tick();
      chk("refetch_mem_en", n_mem_en - b0, 32'd1);
      chk("refetch_if_rdata", if_rdata, 32'h5678);
      fq.push_back(16'h0024);
      drain(20);
      repeat (2) tick();
      b0 = n_mem_en;
      c0 = cyc;
      fq.push_back(16'h0024);
      drain(20);
      repeat (3) tick();
`ifdef MEM_ARB_FETCH_BUF_EN
      chk("hit_no_mem_en", n_mem_en - b0, 32'd0);
      chk("hit_if_valid_c1", lg_iv[c0+1], 32'h1);
`else
      chk("miss_mem_en", n_mem_en - b0, 32'd1);
      chk("miss_if_valid", lg_iv[c0+L+2], 32'h1);
`endif
      chk("repeat_if_rdata", if_rdata, 32'h5A24);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
